// File: rtl/fifo_write_arbiter.sv
// Purpose : round-robin arbiter sharing the single FIFO write port between four requesters, with burst lock.
// Latency : zero-cycle accept; gnt/wr/wr_data are combinational, arbitration state updates on the next edge.
// Backpressure: fifo_full suppresses every grant; nothing is written and all state holds while full.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   req, last    - per-requester write request and end-of-burst marker (bit i = requester i)
//   din          - requester i word at din[i*DATA_W +: DATA_W]
//   fifo_full    - FIFO full flag, same-cycle
//   gnt          - one-hot acceptance strobe
//   wr, wr_data  - FIFO write strobe and data (data is zero when nothing is written)
//   owner        - requester holding, or last holding, the port
//   locked       - a burst is in progress; only owner may write
module fifo_write_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [3:0]            last,
    input  logic [4*DATA_W-1:0]   din,
    input  logic                  fifo_full,
    output logic [3:0]            gnt,
    output logic                  wr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [1:0]            owner,
    output logic                  locked
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic       sel_vld;
    logic [1:0] sel_idx;
    logic       accept;

    assign locked = (state == LOCKED);

    // Pick a candidate: the owner while locked, otherwise the first requester
    // at or after ptr in circular order.
    always_comb begin
        logic [1:0] idx;
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        idx     = 2'd0;
        if (state == LOCKED) begin
            sel_vld = req[owner];
            sel_idx = owner;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr + 2'(k);
                if (!sel_vld && req[idx]) begin
                    sel_vld = 1'b1;
                    sel_idx = idx;
                end
            end
        end
    end

    // Gating with rst_n keeps the write port quiet while reset is held even
    // if requesters are already asserting req.
    assign accept = sel_vld & ~fifo_full & rst_n;

    always_comb begin
        gnt = 4'b0000;
        if (accept) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    assign wr      = accept;
    assign wr_data = accept ? din[sel_idx*DATA_W +: DATA_W] : '0;

    // Only an accepted word moves the state; last from anyone else is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNLOCKED;
            ptr   <= 2'd0;
            owner <= 2'd0;
        end else if (accept) begin
            case (state)
                UNLOCKED: begin
                    owner <= sel_idx;
                    if (last[sel_idx]) begin
                        ptr <= sel_idx + 2'd1;
                    end else begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (last[sel_idx]) begin
                        state <= UNLOCKED;
                        ptr   <= owner + 2'd1;
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares the single write port of the 4096-entry FIFO between four requesters. Each cycle it selects at most one requester by round-robin, drives the FIFO write strobe and data, and returns a one-hot acceptance strobe. A requester may lock the port for a multi-word burst, so packets are never interleaved. The block sits directly in front of the FIFO write-address pointer, whose `fifo_full` it consumes.

## Interface
Parameters:
- `DATA_W`, 8, width of one FIFO word.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester write request, bit i = requester i.
- `last`  in  4  bit i high: requester i's current word ends its burst.
- `din`  in  4*DATA_W  requester i word at bits [i*DATA_W +: DATA_W].
- `fifo_full`  in  1  FIFO full flag, same cycle.
- `gnt`  out  4  one-hot acceptance strobe: word of requester i is written this cycle.
- `wr`  out  1  FIFO write strobe.
- `wr_data`  out  DATA_W  FIFO write data.
- `owner`  out  2  requester holding or last holding the port.
- `locked`  out  1  burst in progress; only `owner` eligible.

## Operation
- State: `ptr[1:0]` (round-robin start), `owner[1:0]`, `locked`. Two states, UNLOCKED and LOCKED, where `locked` is the state bit.
- Eligibility:
  - UNLOCKED: all requesters are eligible.
  - LOCKED: only `owner` is eligible.
- Selection in UNLOCKED: the first requester with `req` high in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Acceptance:
  - `gnt[i]` = selected(i) & `req[i]` & ~`fifo_full`.
  - `wr` = |`gnt`.
  - `wr_data` = `din` slice of the granted requester, else all zeros.
- Transitions are evaluated only on an accepted word (`wr`=1) from requester i:
  - UNLOCKED, `last[i]`=1: stay UNLOCKED; `owner`<=i; `ptr`<=i+1.
  - UNLOCKED, `last[i]`=0: go LOCKED; `owner`<=i; `ptr` unchanged.
  - LOCKED, `last[i]`=1: go UNLOCKED; `ptr`<=owner+1.
  - LOCKED, `last[i]`=0: stay LOCKED.
- No accept: all state holds. This covers `fifo_full`, no eligible request, or the owner deasserting `req` mid-burst. The lock is never broken except by reset; requesters must complete their bursts.
- `ptr` arithmetic is 2-bit and wraps 3 to 0.
- `last` from non-granted requesters is ignored.

## Timing
- Zero-latency accept: `gnt`, `wr`, and `wr_data` are combinational from `req`, `fifo_full`, `din`, and registered state. No word is presented while `fifo_full`=1, so no write is dropped by the pointer's full gating.
- State updates on the rising edge after an accept. The next word can be accepted the following cycle, for a throughput of 1 word/cycle.
- Reset values (asynchronous, on `rst_n`=0): `ptr`=0, `owner`=0, `locked`=0. Consequently `gnt`=0 and `wr`=0 while in reset, and `wr_data`=0.
- Reset mid-burst clears the lock immediately. The next accept after `rst_n` rises is arbitrated from `ptr`=0.
- When `fifo_full` and `req` change in the same cycle, only the current-cycle values count.

## Test plan
- Reset, then `req`=4'b1111, `last`=4'b1111, `fifo_full`=0 for 4 cycles -> `gnt` = 0001, 0010, 0100, 1000 in successive cycles; `wr`=1 each cycle; `wr_data` matches each slice.
- Requester 2 burst: `req`=4'b0101, `last[2]` high only on the 3rd word -> after reset `ptr`=0 grants requester 0 first (`last[0]`=1). Then `gnt`=0100 three times with `locked`=1 during the burst; requester 0 is blocked. On the next cycle requester 0 is granted (ptr=3 wraps to 0).
- `fifo_full` asserted for 5 cycles in the middle of a burst from requester 1 -> `gnt`=0 and `wr`=0 for 5 cycles, `locked`=1 and `owner`=1 held; the burst resumes when full deasserts.
- Owner 3 drops `req` for 2 cycles mid-burst while `req[0]`=1 -> no grants for 2 cycles. On resume, requester 3 is granted; requester 0 is granted only after requester 3's `last`.
- Assert `rst_n`=0 asynchronously mid-burst (between clock edges) -> `locked`, `owner`, and `ptr` go to 0 before the next edge. After release with `req`=4'b1010, `last`=4'b1111 -> the first grant is `gnt`=0010.
- `DATA_W`=16, requester 3 presenting 16'hA5C3 with `req[3]` only -> `wr_data`=16'hA5C3 while `gnt`=1000; `wr_data`=0 when idle.
